// File: rtl/iir_biquad_seq_pkg.sv
// Shared constants for the sequenced biquad: widths, coefficient selector
// codes and the MAC sequencer state encoding.
package iir_biquad_seq_pkg;

  localparam int W     = 25;
  localparam int FRAC  = 19;
  localparam int ACC_W = 56;

  localparam logic [2:0] SEL_A1   = 3'b000;
  localparam logic [2:0] SEL_A2   = 3'b001;
  localparam logic [2:0] SEL_B0   = 3'b010;
  localparam logic [2:0] SEL_B1   = 3'b011;
  localparam logic [2:0] SEL_B2   = 3'b100;
  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MB0  = 3'd1,
    S_MB1  = 3'd2,
    S_MB2  = 3'd3,
    S_MA1  = 3'd4,
    S_MA2  = 3'd5,
    S_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/iir_biquad_seq_sat_round.sv
// Round-half-up and saturate the wide accumulator back down to a Q6.19 sample.
module iir_biquad_seq_sat_round
  import iir_biquad_seq_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [W-1:0]     y_o
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  // Add half an output LSB, drop the fraction arithmetically, then clamp to W bits.
  always_comb begin
    rounded = acc_i + HALF;
    shifted = rounded >>> FRAC;
    if (shifted > MAXV) begin
      y_o = MAXV[W-1:0];
    end else if (shifted < MINV) begin
      y_o = MINV[W-1:0];
    end else begin
      y_o = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/iir_biquad_seq.sv
// Single-MAC direct-form-I biquad. One sample per handshake, five MAC cycles
// fetching coefficients through the selector, then round/saturate and shift
// the delay line.
module iir_biquad_seq
  import iir_biquad_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] x_in,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic                clear,
  output logic [2:0]          selector,
  input  logic signed [W-1:0] coef,
  output logic signed [W-1:0] y_out,
  output logic                y_valid
);

  state_e state_q, state_d;

  logic signed [W-1:0]     x_reg_q, x_reg_d;
  logic signed [W-1:0]     x1_q, x1_d;
  logic signed [W-1:0]     x2_q, x2_d;
  logic signed [W-1:0]     y1_q, y1_d;
  logic signed [W-1:0]     y2_q, y2_d;
  logic signed [W-1:0]     y_out_q, y_out_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    y_valid_q, y_valid_d;
  logic                    x_ready_q, x_ready_d;

  logic [2:0]              sel;
  logic signed [W-1:0]     operand;
  logic signed [2*W-1:0]   prod;
  logic signed [W-1:0]     y_sat;

  iir_biquad_seq_sat_round u_sat_round (
    .acc_i (acc_q),
    .y_o   (y_sat)
  );

  // Coefficient select and matching delay-line operand, decoded from the registered state.
  always_comb begin
    sel     = SEL_IDLE;
    operand = '0;
    case (state_q)
      S_MB0: begin sel = SEL_B0; operand = x_reg_q; end
      S_MB1: begin sel = SEL_B1; operand = x1_q;    end
      S_MB2: begin sel = SEL_B2; operand = x2_q;    end
      S_MA1: begin sel = SEL_A1; operand = y1_q;    end
      S_MA2: begin sel = SEL_A2; operand = y2_q;    end
      default: begin sel = SEL_IDLE; operand = '0; end
    endcase
  end

  assign prod = coef * operand;

  // Sequencer: accept a sample, accumulate five products, then emit and shift the delay line.
  always_comb begin
    state_d   = state_q;
    x_reg_d   = x_reg_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y_out_d   = y_out_q;
    acc_d     = acc_q;
    y_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (x_valid && x_ready_q) begin
          x_reg_d = x_in;
          acc_d   = '0;
          state_d = S_MB0;
        end else if (clear) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end
      end
      S_MB0, S_MB1, S_MB2, S_MA1, S_MA2: begin
        acc_d = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        case (state_q)
          S_MB0:   state_d = S_MB1;
          S_MB1:   state_d = S_MB2;
          S_MB2:   state_d = S_MA1;
          S_MA1:   state_d = S_MA2;
          default: state_d = S_DONE;
        endcase
      end
      S_DONE: begin
        y_out_d   = y_sat;
        y_valid_d = 1'b1;
        x2_d      = x1_q;
        x1_d      = x_reg_q;
        y2_d      = y1_q;
        y1_d      = y_sat;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    x_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; ready stays low through reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_reg_q   <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_out_q   <= '0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_reg_q   <= x_reg_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y_out_q   <= y_out_d;
      acc_q     <= acc_d;
      y_valid_q <= y_valid_d;
      x_ready_q <= x_ready_d;
    end
  end

  assign selector = sel;
  assign x_ready  = x_ready_q;
  assign y_out    = y_out_q;
  assign y_valid  = y_valid_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Self-checking bench for iir_biquad_seq: a behavioural fixed-point model
// pushes expected outputs on each accepted sample, a monitor collects DUT
// results, and each scenario task compares them inline.
module tb_iir_biquad_seq;

  localparam int W = 25;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic                x_valid = 1'b0;
  logic                x_ready;
  logic                clear = 1'b0;
  logic [2:0]          selector;
  logic signed [W-1:0] coef;
  logic signed [W-1:0] y_out;
  logic                y_valid;

  int compared = 0;
  int mismatched = 0;
  int coefMode = 0;

  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  longint expq[$];
  logic signed [W-1:0] gotq[$];

  iir_biquad_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .clear    (clear),
    .selector (selector),
    .coef     (coef),
    .y_out    (y_out),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  // Coefficient constants: mode 0 is the standard filter, mode 1 drives b0 to full scale only.
  function automatic longint coef_val(input logic [2:0] sel, input int m);
    longint v;
    v = 0;
    case (sel)
      3'b010: v = (m == 1) ? 64'sd16777215 : 64'sd3;
      3'b011: v = (m == 1) ? 64'sd0 : 64'sd7;
      3'b100: v = (m == 1) ? 64'sd0 : 64'sd3;
      3'b000: v = (m == 1) ? 64'sd0 : 64'sd1027604;
      3'b001: v = (m == 1) ? 64'sd0 : -64'sd503579;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Combinational constant mux answering the DUT's selector in the same cycle.
  always_comb begin
    longint cv;
    cv = coef_val(selector, coefMode);
    coef = cv[W-1:0];
  end

  // Collect every y_valid pulse so scenarios can pop results in order.
  always @(negedge clk) begin
    if (rst_n && y_valid) gotq.push_back(y_out);
  end

  // Reference biquad in plain integer arithmetic with round-half-up and saturation.
  task automatic model_push(input logic signed [W-1:0] x);
    longint acc, r, xv;
    xv  = longint'(x);
    acc = coef_val(3'b010, coefMode) * xv  + coef_val(3'b011, coefMode) * mx1 +
          coef_val(3'b100, coefMode) * mx2 + coef_val(3'b000, coefMode) * my1 +
          coef_val(3'b001, coefMode) * my2;
    r = (acc + 64'sd262144) >>> 19;
    if (r > 64'sd16777215) r = 64'sd16777215;
    if (r < -64'sd16777216) r = -64'sd16777216;
    expq.push_back(r);
    mx2 = mx1; mx1 = xv; my2 = my1; my1 = r;
  endtask

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // Offer a sample, wait (bounded) for the handshake edge, then drop valid.
  task automatic send_sample(input logic signed [W-1:0] x, input logic withClear);
    int n;
    @(negedge clk);
    x_in = x; x_valid = 1'b1; clear = withClear;
    n = 0;
    while (!x_ready && n < 40) begin @(negedge clk); n++; end
    compared++;
    if (!x_ready) begin
      mismatched++;
      $display("[TB] FAIL handshake_timeout: x_ready=%0b required 1", x_ready);
      x_valid = 1'b0; clear = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(x);
    #1;
    x_valid = 1'b0; clear = 1'b0;
  endtask

  // Wait (bounded) for the monitor to capture a result.
  task automatic wait_result(output logic signed [W-1:0] v);
    int n;
    n = 0;
    v = '0;
    while (gotq.size() == 0 && n < 40) begin @(negedge clk); #1; n++; end
    compared++;
    if (gotq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL result_timeout: no y_valid within %0d cycles", n);
    end else begin
      v = gotq.pop_front();
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (selector !== 3'b111 || x_ready !== 1'b0 || y_out !== '0 || y_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: sel=%b rdy=%b y=%h yv=%b required 111 0 0 0",
               selector, x_ready, y_out, y_valid);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (x_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ready_at_release: got %b required 0", x_ready);
    end
    @(negedge clk);
    compared++;
    if (x_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ready_after_release: got %b required 1", x_ready);
    end
  endtask

  task automatic test_impulse();
    logic [2:0] selTab [5];
    logic signed [W-1:0] v;
    longint e;
    selTab = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b001};
    coefMode = 0;
    send_sample(25'sd524288, 1'b0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      compared++;
      if (selector !== selTab[j] || x_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL selector_order[%0d]: sel=%b rdy=%b required %b 0",
                 j, selector, x_ready, selTab[j]);
      end
    end
    @(negedge clk);
    compared++;
    if (y_valid !== 1'b0 || selector !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL done_cycle: yv=%b sel=%b required 0 111", y_valid, selector);
    end
    @(negedge clk);
    compared++;
    if (y_valid !== 1'b1 || y_out !== 25'sd3) begin
      mismatched++;
      $display("[TB] FAIL impulse_y0_latency: yv=%b y=%0d required 1 3", y_valid, y_out);
    end
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL impulse_y0_model: got %0d required %0d", v, e);
    end
    send_sample('0, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== 25'sd13 || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL impulse_y1: got %0d required 13 (model %0d)", v, e);
    end
    for (int j = 0; j < 4; j++) begin
      send_sample('0, 1'b0);
      wait_result(v);
      e = expq.pop_front();
      compared++;
      if (v !== W'(e)) begin
        mismatched++;
        $display("[TB] FAIL impulse_tail[%0d]: got %0d required %0d", j, v, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] v;
    longint e;
    time t1, t2;
    logic readyLow;
    int n;
    @(negedge clk);
    x_in = 25'sd100000; x_valid = 1'b1;
    n = 0;
    while (!x_ready && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    t1 = $time;
    model_push(x_in);
    #1 x_in = -25'sd250000;
    readyLow = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (x_ready !== 1'b0) readyLow = 1'b0;
    end
    compared++;
    if (readyLow !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_ready_low: ready rose during MB0..DONE, required low");
    end
    n = 0;
    while (!x_ready && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    t2 = $time;
    model_push(x_in);
    #1 x_valid = 1'b0;
    compared++;
    if (t2 - t1 != 70) begin
      mismatched++;
      $display("[TB] FAIL b2b_spacing: got %0t required 70", t2 - t1);
    end
    for (int j = 0; j < 2; j++) begin
      wait_result(v);
      e = expq.pop_front();
      compared++;
      if (v !== W'(e)) begin
        mismatched++;
        $display("[TB] FAIL b2b_result[%0d]: got %0d required %0d", j, v, e);
      end
    end
    repeat (12) @(negedge clk);
    #1;
    compared++;
    if (gotq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_duplicate: %0d extra results required 0", gotq.size());
    end
  endtask

  task automatic test_saturation();
    logic signed [W-1:0] v;
    longint e;
    coefMode = 1;
    send_sample(25'h0800000, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== 25'h0FFFFFF || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL sat_pos: got %h required 0ffffff (model %0d)", v, e);
    end
    send_sample(25'h1800000, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== 25'h1000000 || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL sat_neg: got %h required 1000000 (model %0d)", v, e);
    end
    coefMode = 0;
  endtask

  task automatic test_clear();
    logic signed [W-1:0] v;
    longint e;
    int n;
    pulse_clear();
    send_sample(25'sd524288, 1'b0);
    wait_result(v);
    void'(expq.pop_front());
    pulse_clear();
    send_sample('0, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== '0 || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL clear_idle: got %0d required 0", v);
    end
    send_sample(25'sd524288, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== 25'sd3) begin
      mismatched++;
      $display("[TB] FAIL clear_rebuild: got %0d required 3 (model %0d)", v, e);
    end
    send_sample('0, 1'b0);
    n = 0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== 25'sd13 || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL clear_in_ma1: got %0d required 13 (model %0d)", v, e);
    end
    send_sample('0, 1'b1);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== W'(e) || v === '0) begin
      mismatched++;
      $display("[TB] FAIL clear_with_valid: got %0d required %0d", v, e);
    end
  endtask

  task automatic test_reset_midop();
    logic signed [W-1:0] v;
    longint e;
    send_sample(25'sd524288, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (selector !== 3'b111 || y_out !== '0 || y_valid !== 1'b0 || x_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midop_reset: sel=%b y=%h yv=%b rdy=%b required 111 0 0 0",
               selector, y_out, y_valid, x_ready);
    end
    model_clear();
    expq.delete();
    repeat (10) @(negedge clk);
    #1;
    compared++;
    if (gotq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midop_no_pulse: %0d results required 0", gotq.size());
    end
    rst_n = 1'b1;
    send_sample('0, 1'b0);
    wait_result(v);
    e = expq.pop_front();
    compared++;
    if (v !== '0 || v !== W'(e)) begin
      mismatched++;
      $display("[TB] FAIL midop_after_release: got %0d required 0", v);
    end
  endtask

  task automatic test_dc();
    logic signed [W-1:0] v;
    longint e, d;
    logic sawSat;
    pulse_clear();
    sawSat = 1'b0;
    v = '0;
    for (int j = 0; j < 2000; j++) begin
      send_sample(25'sd524288, 1'b0);
      wait_result(v);
      e = expq.pop_front();
      d = longint'(v) - e;
      if (v === 25'h0FFFFFF || v === 25'h1000000) sawSat = 1'b1;
      compared++;
      if (d > 2 || d < -2) begin
        mismatched++;
        $display("[TB] FAIL dc_track[%0d]: got %0d required %0d +-2", j, v, e);
      end
    end
    compared++;
    if (sawSat !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dc_no_saturation: saturated output seen, required none");
    end
    compared++;
    if (v < 25'sd23593 || v > 25'sd27787) begin
      mismatched++;
      $display("[TB] FAIL dc_final: got %0d required about 25916", v);
    end
  endtask

  // Hard upper bound on run time in case a scenario wedges.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_reset_midop();
    test_dc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
